// File: rtl/apb_pwm_timer.sv
// apb_pwm_timer
//   APB3 slave (zero wait states) wrapping one PWM / interval timer.
//   Claims the 1 MiB window whose top 12 address bits equal BASE_ADR.
//   Register map (offset from base):
//     0x00 CTRL     bit0 MODE (0 continuous, 1 one-shot), bit1 GO_EN
//     0x04 TOT_CNT  period in PCLK cycles
//     0x08 DUTY_CNT PWM high cycles per period
// Ports:
//   PCLK, PRESETn                    clock, async active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB request
//   PREADY/PRDATA/PSLVERR            APB response (PRDATA combinational)
//   IRQ                              one-cycle pulse after each period end
//   PWM                              registered PWM waveform
module apb_pwm_timer #(
    parameter logic [11:0] BASE_ADR = 12'h44a,
    parameter int          ADR_W    = 32,
    parameter int          DAT_W    = 32
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [ADR_W-1:0] PADDR,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [DAT_W-1:0] PWDATA,
    output logic             PREADY,
    output logic [DAT_W-1:0] PRDATA,
    output logic             PSLVERR,
    output logic             IRQ,
    output logic             PWM
);
    localparam logic [ADR_W-13:0] OFF_CTRL = '0;
    localparam logic [ADR_W-13:0] OFF_TOT  = (ADR_W-12)'(4);
    localparam logic [ADR_W-13:0] OFF_DUTY = (ADR_W-12)'(8);
    localparam logic [DAT_W-1:0]  ONE      = DAT_W'(1);

    logic             r_mode, r_go, r_pwm, r_irq;
    logic [DAT_W-1:0] r_tot, r_duty, r_cnt, r_sh_tot, r_sh_duty;

    logic             w_access, w_valid, w_wr, w_run, w_end;
    logic [ADR_W-13:0] w_off;
    logic             w_mode_nxt, w_go_nxt, w_irq_nxt, w_pwm_nxt;
    logic [DAT_W-1:0] w_tot_nxt, w_duty_nxt, w_cnt_nxt, w_sh_tot_nxt, w_sh_duty_nxt;

    assign w_access = PSEL & PENABLE & (PADDR[ADR_W-1:ADR_W-12] == BASE_ADR);
    assign w_off    = PADDR[ADR_W-13:0];
    assign w_valid  = (w_off == OFF_CTRL) | (w_off == OFF_TOT) | (w_off == OFF_DUTY);
    assign w_wr     = w_access & PWRITE & w_valid;

    // Counting only happens with a non-zero shadow period; the wrap compare
    // uses TOT-1 so an all-ones period never needs the counter to overflow.
    assign w_run = r_go & (r_sh_tot != '0);
    assign w_end = (r_cnt == r_sh_tot - ONE);

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_valid;
    assign IRQ     = r_irq;
    assign PWM     = r_pwm;

    always_comb begin
        PRDATA = '0;
        if (w_access) begin
            case (w_off)
                OFF_CTRL: PRDATA = {{(DAT_W-2){1'b0}}, r_go, r_mode};
                OFF_TOT:  PRDATA = r_tot;
                OFF_DUTY: PRDATA = r_duty;
                default:  PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        w_mode_nxt    = r_mode;
        w_go_nxt      = r_go;
        w_tot_nxt     = r_tot;
        w_duty_nxt    = r_duty;
        w_cnt_nxt     = r_cnt;
        w_sh_tot_nxt  = r_sh_tot;
        w_sh_duty_nxt = r_sh_duty;
        w_irq_nxt     = 1'b0;

        if (w_run) begin
            if (w_end) begin
                // Period boundary: restart and pick up any mid-period writes.
                w_cnt_nxt     = '0;
                w_sh_tot_nxt  = r_tot;
                w_sh_duty_nxt = r_duty;
                w_irq_nxt     = 1'b1;
                if (r_mode) w_go_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = '0;
        end

        // Software writes come last so a CTRL write beats the one-shot clear.
        if (w_wr) begin
            case (w_off)
                OFF_CTRL: begin
                    w_mode_nxt = PWDATA[0];
                    w_go_nxt   = PWDATA[1];
                    if (PWDATA[1] && !r_go) begin
                        w_sh_tot_nxt  = r_tot;
                        w_sh_duty_nxt = r_duty;
                        w_cnt_nxt     = '0;
                    end
                    if (!PWDATA[1]) w_cnt_nxt = '0;
                end
                OFF_TOT:  w_tot_nxt  = PWDATA;
                OFF_DUTY: w_duty_nxt = PWDATA;
                default:  ;
            endcase
        end

        // PWM is registered from the next-cycle state so it lines up with the
        // counter value it describes and drops on the same edge GO_EN clears.
        w_pwm_nxt = w_go_nxt & (w_sh_tot_nxt != '0) & (w_cnt_nxt < w_sh_duty_nxt);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mode    <= 1'b0;
            r_go      <= 1'b0;
            r_tot     <= '0;
            r_duty    <= '0;
            r_cnt     <= '0;
            r_sh_tot  <= '0;
            r_sh_duty <= '0;
            r_irq     <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_go      <= w_go_nxt;
            r_tot     <= w_tot_nxt;
            r_duty    <= w_duty_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sh_tot  <= w_sh_tot_nxt;
            r_sh_duty <= w_sh_duty_nxt;
            r_irq     <= w_irq_nxt;
            r_pwm     <= w_pwm_nxt;
        end
    end
endmodule

// File: tb/tb_apb_pwm_timer.sv
// Bench for apb_pwm_timer: directed APB steps plus randomized timer setups.
// A negedge monitor compares PWM/IRQ each cycle against a period/duty model
// expressed as arithmetic on the cycle index since start.
module tb_apb_pwm_timer;
    localparam logic [31:0] BASE = 32'h44A0_0000;

    logic        PCLK = 1'b0, PRESETn = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic        PREADY, PSLVERR, IRQ, PWM;
    logic [31:0] PRDATA;

    apb_pwm_timer #(.BASE_ADR(12'h44a), .ADR_W(32), .DAT_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR), .IRQ(IRQ), .PWM(PWM));

    always #5 PCLK = ~PCLK;

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // model state, written by the main sequence
    bit mon_en = 0, run = 0, oneshot = 0;
    int t0 = 0, stop_t = 0, per1 = 0, per2 = 0, duty1 = 0, duty2 = 0;
    int mon_bad = 0, mon_n = 0, bad0 = 0, n0 = 0;

    function automatic logic exp_pwm(int c);
        int k = c - t0;
        if (!run || per1 == 0) return 1'b0;
        if (k < per1) return k < duty1;
        if (oneshot) return 1'b0;
        return ((k - per1) % per2) < duty2;
    endfunction

    function automatic logic exp_irq(int c);
        int k = c - t0;
        if (!run || per1 == 0 || k < per1) return 1'b0;
        if (oneshot) return k == per1;
        return ((k - per1) % per2) == 0;
    endfunction

    // The cycle right after a stop may still carry a pulse registered on the
    // stop edge, so IRQ is not judged there.
    always @(negedge PCLK) begin
        if (mon_en) begin
            mon_n <= mon_n + 1;
            if (PWM !== exp_pwm(cyc) ||
                (!(!run && cyc == stop_t) && IRQ !== exp_irq(cyc)))
                mon_bad <= mon_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic phase(input string tag);
        chk({tag, "_wave"}, 32'(mon_bad - bad0), 32'd0);
        chk({tag, "_ran"}, 32'(mon_n > n0), 32'd1);
        bad0 = mon_bad;
        n0   = mon_n;
    endtask

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 rd = PRDATA; err = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] rd; logic err;
        apb(1'b1, BASE + off, d, rd, err);
        chk("wr_slverr", {31'd0, err}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; logic err;
        apb(1'b0, BASE + off, 32'd0, rd, err);
        chk(tag, rd, exp);
    endtask

    task automatic stop();
        wr(32'h0, 32'h0);
        run = 0; stop_t = cyc;
    endtask

    task automatic start(input int tot, input int duty, input bit mode, input int tot2);
        wr(32'h0, {30'd0, 1'b1, mode});
        t0 = cyc; per1 = tot; per2 = tot2; duty1 = duty; duty2 = duty;
        oneshot = mode; run = 1;
    endtask

    task automatic wait_k(input int n);
        while (cyc - t0 < n) @(posedge PCLK);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          tot, duty;
        bit          mode;

        // reset state
        #12;
        chk("rst_pwm", {31'd0, PWM}, 32'd0);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_slverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_pready", {31'd0, PREADY}, 32'd1);
        @(negedge PCLK) PRESETn = 1'b1;
        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_tot", 32'h4, 32'h0);
        rd_chk("rst_duty", 32'h8, 32'h0);
        stop_t = cyc; mon_en = 1;

        // continuous 16384 / 7000, with a period change to 100 mid-period
        stop();
        wr(32'h4, 32'd16384);
        wr(32'h8, 32'd7000);
        start(16384, 7000, 1'b0, 100);
        apb(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, rd, err);
        chk("bad_0c_slverr", {31'd0, err}, 32'd1);
        apb(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, rd, err);
        chk("bad_10_slverr", {31'd0, err}, 32'd1);
        apb(1'b0, BASE + 32'h2, 32'h0, rd, err);
        chk("unaligned_slverr", {31'd0, err}, 32'd1);
        chk("unaligned_prdata", rd, 32'd0);
        apb(1'b1, 32'h1234_0004, 32'd5, rd, err);
        chk("other_base_slverr", {31'd0, err}, 32'd0);
        rd_chk("run_ctrl", 32'h0, 32'h0000_0002);
        rd_chk("run_tot", 32'h4, 32'h0000_4000);
        rd_chk("run_duty", 32'h8, 32'h0000_1B58);
        chk("pready", {31'd0, PREADY}, 32'd1);
        wr(32'h4, 32'd100);
        rd_chk("new_tot", 32'h4, 32'd100);
        wait_k(16384 + 537);
        stop();
        repeat (250) @(posedge PCLK);
        phase("long_run");
        rd_chk("stopped_ctrl", 32'h0, 32'h0);

        // one-shot 10 / 3
        wr(32'h4, 32'd10);
        wr(32'h8, 32'd3);
        start(10, 3, 1'b1, 10);
        wait_k(40);
        rd_chk("oneshot_ctrl", 32'h0, 32'h1);
        phase("oneshot");

        // DUTY=0, then DUTY=TOT=8
        stop();
        wr(32'h4, 32'd8);
        wr(32'h8, 32'd0);
        start(8, 0, 1'b0, 8);
        wait_k(40);
        stop();
        phase("duty0");
        wr(32'h8, 32'd8);
        start(8, 8, 1'b0, 8);
        wait_k(43);
        phase("duty_full");

        // asynchronous reset in the middle of a period
        @(posedge PCLK);
        #1 mon_en = 0;
        chk("pre_rst_pwm", {31'd0, PWM}, 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_rst_pwm", {31'd0, PWM}, 32'd0);
        chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
        @(negedge PCLK) PRESETn = 1'b1;
        rd_chk("post_rst_ctrl", 32'h0, 32'h0);
        rd_chk("post_rst_tot", 32'h4, 32'h0);
        rd_chk("post_rst_duty", 32'h8, 32'h0);
        run = 0; stop_t = cyc; bad0 = mon_bad; n0 = mon_n; mon_en = 1;

        // randomized setups
        for (int t = 0; t < 8; t++) begin
            tot  = $urandom_range(0, 30);
            duty = $urandom_range(0, tot + 2);
            mode = 1'($urandom_range(0, 1));
            stop();
            wr(32'h4, 32'(tot));
            wr(32'h8, 32'(duty));
            start(tot, duty, mode, tot);
            wait_k(3 * tot + 6);
            rd_chk("rand_ctrl", 32'h0, (mode && tot != 0) ? 32'h1 : {30'd0, 1'b1, mode});
            phase("rand");
        end
        stop();
        repeat (5) @(posedge PCLK);
        phase("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
